// File: rtl/module_mem_pkg.sv
// Shared encodings for the MEM stage: control-field positions, access sizes,
// FSM states and the default bus timeout.
package module_mem_pkg;

    localparam int CTRL_READ    = 4;
    localparam int CTRL_WRITE   = 3;
    localparam int CTRL_UNS     = 2;
    localparam int CTRL_SIZE_HI = 1;
    localparam int CTRL_SIZE_LO = 0;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_WORD_X = 2'b11;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // A half access must be even, a word access must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_BYTE:              mis = 1'b0;
            SIZE_HALF:              mis = offset[0];
            SIZE_WORD, SIZE_WORD_X: mis = (offset != 2'b00);
            default:                mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/module_mem_lsu_align.sv
// Byte-lane steering: byte enables and store replication for the outgoing
// access, lane extraction and sign/zero extension for the returning word.
module module_mem_lsu_align
    import module_mem_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: enables follow the address, data fills every lane of the size.
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_size)
            SIZE_BYTE: begin
                be    = 4'b0001 << st_offset;
                wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                be    = 4'b0011 << st_offset;
                wdata = {2{st_data[15:0]}};
            end
            SIZE_WORD, SIZE_WORD_X: begin
                be    = 4'b1111;
                wdata = st_data;
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane and widen it to 32 bits.
    always_comb begin
        byte_s  = rdata[{ld_offset, 3'b000} +: 8];
        half_s  = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        case (ld_size)
            SIZE_BYTE: begin
                if (ld_unsigned) begin
                    ld_data = {24'h000000, byte_s};
                end else begin
                    ld_data = {{24{byte_s[7]}}, byte_s};
                end
            end
            SIZE_HALF: begin
                if (ld_unsigned) begin
                    ld_data = {16'h0000, half_s};
                end else begin
                    ld_data = {{16{half_s[15]}}, half_s};
                end
            end
            SIZE_WORD, SIZE_WORD_X: ld_data = rdata;
            default:                ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/module_mem.sv
// MEM pipeline stage: issues one data-memory access per memory op, stalls the
// pipeline while it waits, and registers the MEM/WB results.
module module_mem
    import module_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic [4:0]  mem_ctrl_i,
    input  logic [1:0]  wb_ctrl_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  Rd_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [1:0]  wb_ctrl_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] data_o,
    output logic [4:0]  wb_Rd_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_e state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;

    logic        mem_op_s, misalign_s, start_s, ack_s, timeout_s;
    logic        stall_s, req_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, ld_data_s;

    logic [31:0] addr_r, wdata_r;
    logic [3:0]  be_r;
    logic        we_r, uns_r;
    logic [1:0]  size_r, wbc_lat_r;
    logic [4:0]  rd_lat_r;

    logic [1:0]  wb_ctrl_r;
    logic [31:0] wb_data_r, data_r;
    logic [4:0]  wb_rd_r;
    logic        misalign_r, bus_err_r;

    // Exactly one of read/write makes a memory op; both set falls through as ALU.
    assign mem_op_s   = mem_valid_i & (mem_ctrl_i[CTRL_READ] ^ mem_ctrl_i[CTRL_WRITE]);
    assign misalign_s = mem_op_s & is_misaligned(mem_ctrl_i[CTRL_SIZE_HI:CTRL_SIZE_LO],
                                                 alu_result_i[1:0]);
    assign start_s    = (state_r == ST_IDLE) & mem_op_s & ~misalign_s;
    assign ack_s      = (state_r == ST_WAIT) & dmem_ack_i;
    assign timeout_s  = (state_r == ST_WAIT) & ~dmem_ack_i & (cnt_r == LAST_CNT);

    module_mem_lsu_align u_align (
        .st_offset   (alu_result_i[1:0]),
        .st_size     (mem_ctrl_i[CTRL_SIZE_HI:CTRL_SIZE_LO]),
        .st_data     (store_data_i),
        .be          (be_s),
        .wdata       (wdata_s),
        .ld_offset   (addr_r[1:0]),
        .ld_size     (size_r),
        .ld_unsigned (uns_r),
        .rdata       (dmem_rdata_i),
        .ld_data     (ld_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ack_s || timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs; the final timeout cycle releases the stall.
    always_comb begin
        stall_s = 1'b0;
        req_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = start_s;
                req_s   = 1'b0;
            end
            ST_WAIT: begin
                stall_s = ~dmem_ack_i & ~timeout_s;
                req_s   = 1'b1;
            end
            default: begin
                stall_s = 1'b0;
                req_s   = 1'b0;
            end
        endcase
    end

    // Wait-cycle counter, cleared whenever not waiting or on ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !dmem_ack_i) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Access latch, captured when a memory op is accepted in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            be_r      <= 4'b0000;
            we_r      <= 1'b0;
            uns_r     <= 1'b0;
            size_r    <= 2'b00;
            wbc_lat_r <= 2'b00;
            rd_lat_r  <= 5'd0;
        end else if (start_s) begin
            addr_r    <= alu_result_i;
            wdata_r   <= wdata_s;
            be_r      <= be_s;
            we_r      <= mem_ctrl_i[CTRL_WRITE];
            uns_r     <= mem_ctrl_i[CTRL_UNS];
            size_r    <= mem_ctrl_i[CTRL_SIZE_HI:CTRL_SIZE_LO];
            wbc_lat_r <= wb_ctrl_i;
            rd_lat_r  <= Rd_i;
        end else begin
            addr_r    <= addr_r;
            wdata_r   <= wdata_r;
            be_r      <= be_r;
            we_r      <= we_r;
            uns_r     <= uns_r;
            size_r    <= size_r;
            wbc_lat_r <= wbc_lat_r;
            rd_lat_r  <= rd_lat_r;
        end
    end

    // MEM/WB register: completions load results, every other cycle is a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ctrl_r  <= 2'b00;
            wb_data_r  <= 32'h0000_0000;
            data_r     <= 32'h0000_0000;
            wb_rd_r    <= 5'd0;
            misalign_r <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            wb_ctrl_r  <= 2'b00;
            misalign_r <= 1'b0;
            bus_err_r  <= 1'b0;
            if (ack_s) begin
                wb_ctrl_r <= wbc_lat_r;
                wb_data_r <= addr_r;
                data_r    <= we_r ? 32'h0000_0000 : ld_data_s;
                wb_rd_r   <= rd_lat_r;
            end else if (timeout_s) begin
                bus_err_r <= 1'b1;
            end else if (misalign_s && (state_r == ST_IDLE)) begin
                misalign_r <= 1'b1;
            end else if (mem_valid_i && !mem_op_s && (state_r == ST_IDLE)) begin
                wb_ctrl_r <= wb_ctrl_i;
                wb_data_r <= alu_result_i;
                data_r    <= 32'h0000_0000;
                wb_rd_r   <= Rd_i;
            end else begin
                wb_data_r <= wb_data_r;
                data_r    <= data_r;
                wb_rd_r   <= wb_rd_r;
            end
        end
    end

    // Stall must read zero during reset even if a memory op sits on the inputs.
    assign stall_o      = stall_s & ~rst_i;
    assign dmem_req_o   = req_s;
    assign dmem_we_o    = req_s & we_r;
    assign dmem_addr_o  = {addr_r[31:2], 2'b00};
    assign dmem_wdata_o = wdata_r;
    assign dmem_be_o    = be_r;
    assign wb_ctrl_o    = wb_ctrl_r;
    assign wb_data_o    = wb_data_r;
    assign data_o       = data_r;
    assign wb_Rd_o      = wb_rd_r;
    assign misalign_o   = misalign_r;
    assign bus_err_o    = bus_err_r;

endmodule

// File: tb/tb_module_mem.sv
// Directed self-checking bench for the MEM stage, built with a 4-cycle timeout.
module tb_module_mem;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_valid_i;
    logic [4:0]  mem_ctrl_i;
    logic [1:0]  wb_ctrl_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [4:0]  Rd_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [1:0]  wb_ctrl_o;
    logic [31:0] wb_data_o;
    logic [31:0] data_o;
    logic [4:0]  wb_Rd_o;
    logic        misalign_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    module_mem #(.TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ctrl_i   (mem_ctrl_i),
        .wb_ctrl_i    (wb_ctrl_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .Rd_i         (Rd_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_ctrl_o    (wb_ctrl_o),
        .wb_data_o    (wb_data_o),
        .data_o       (data_o),
        .wb_Rd_o      (wb_Rd_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic drive_op(input logic v, input logic [4:0] ctrl, input logic [1:0] wbc,
                            input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
        mem_valid_i  = v;
        mem_ctrl_i   = ctrl;
        wb_ctrl_i    = wbc;
        alu_result_i = addr;
        store_data_i = sdata;
        Rd_i         = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive_op(1'b0, 5'b00000, 2'b00, 32'h0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b exp 0", dmem_req_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b exp 0", stall_o); end
        total++; if (wb_ctrl_o !== 2'b00) begin bad++; $display("FAIL reset_wbctrl: got %b exp 00", wb_ctrl_o); end
        total++; if ({wb_data_o, data_o} !== 64'h0) begin bad++; $display("FAIL reset_data: got %h %h exp 0", wb_data_o, data_o); end
        total++; if ({wb_Rd_o, misalign_o, bus_err_o} !== 7'h0) begin bad++; $display("FAIL reset_misc: got %h exp 0", {wb_Rd_o, misalign_o, bus_err_o}); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        drive_op(1'b1, 5'b10010, 2'b11, 32'h0000_0100, 32'h0, 5'd5);
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lw_stall_idle: got %b exp 1", stall_o); end
        @(negedge clk);
        total++; if ({dmem_req_o, dmem_we_o} !== 2'b10) begin bad++; $display("FAIL lw_req_we: got %b exp 10", {dmem_req_o, dmem_we_o}); end
        total++; if (dmem_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL lw_addr: got %h exp 00000100", dmem_addr_o); end
        total++; if (dmem_be_o !== 4'b1111) begin bad++; $display("FAIL lw_be: got %b exp 1111", dmem_be_o); end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lw_stall_ack: got %b exp 0", stall_o); end
        @(negedge clk);
        dmem_ack_i = 1'b0;
        mem_valid_i = 1'b0;
        total++; if (data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data: got %h exp deadbeef", data_o); end
        total++; if (wb_ctrl_o !== 2'b11) begin bad++; $display("FAIL lw_wbctrl: got %b exp 11", wb_ctrl_o); end
        total++; if ({wb_data_o, wb_Rd_o} !== {32'h0000_0100, 5'd5}) begin bad++; $display("FAIL lw_wb: got %h %0d exp 00000100 5", wb_data_o, wb_Rd_o); end
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL lw_req_drop: got %b exp 0", dmem_req_o); end
        @(negedge clk);
        total++; if (wb_ctrl_o !== 2'b00) begin bad++; $display("FAIL lw_bubble: got %b exp 00", wb_ctrl_o); end
    endtask

    task automatic test_lb();
        logic [4:0]  ctrls [2];
        logic [31:0] exps  [2];
        ctrls[0] = 5'b10000; exps[0] = 32'hFFFF_FF80;
        ctrls[1] = 5'b10100; exps[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            drive_op(1'b1, ctrls[i], 2'b11, 32'h0000_0103, 32'h0, 5'd9);
            @(negedge clk);
            total++; if (dmem_be_o !== 4'b1000) begin bad++; $display("FAIL lb_be[%0d]: got %b exp 1000", i, dmem_be_o); end
            total++; if (dmem_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL lb_addr[%0d]: got %h exp 00000100", i, dmem_addr_o); end
            dmem_ack_i = 1'b1;
            dmem_rdata_i = 32'h8012_3456;
            @(negedge clk);
            dmem_ack_i = 1'b0;
            mem_valid_i = 1'b0;
            total++; if (data_o !== exps[i]) begin bad++; $display("FAIL lb_data[%0d]: got %h exp %h", i, data_o, exps[i]); end
        end
    endtask

    task automatic test_sh();
        drive_op(1'b1, 5'b01001, 2'b00, 32'h0000_0102, 32'hABCD_1234, 5'd0);
        @(negedge clk);
        total++; if (dmem_be_o !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b exp 1100", dmem_be_o); end
        total++; if (dmem_wdata_o !== 32'h1234_1234) begin bad++; $display("FAIL sh_wdata: got %h exp 12341234", dmem_wdata_o); end
        total++; if ({dmem_req_o, dmem_we_o} !== 2'b11) begin bad++; $display("FAIL sh_req_we: got %b exp 11", {dmem_req_o, dmem_we_o}); end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h5555_5555;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        mem_valid_i = 1'b0;
        total++; if ({data_o, wb_data_o} !== {32'h0, 32'h0000_0102}) begin bad++; $display("FAIL sh_wb: got %h %h exp 00000000 00000102", data_o, wb_data_o); end
    endtask

    task automatic test_misalign();
        drive_op(1'b1, 5'b10010, 2'b11, 32'h0000_0101, 32'h0, 5'd3);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b exp 0", stall_o); end
        @(negedge clk);
        mem_valid_i = 1'b0;
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL mis_req: got %b exp 0", dmem_req_o); end
        total++; if ({misalign_o, wb_ctrl_o} !== 3'b100) begin bad++; $display("FAIL mis_pulse: got %b exp 100", {misalign_o, wb_ctrl_o}); end
        @(negedge clk);
        total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_end: got %b exp 0", misalign_o); end
    endtask

    task automatic test_timeout(input logic ack_last);
        drive_op(1'b1, 5'b10010, 2'b11, 32'h0000_0200, 32'h0, 5'd4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4 && ack_last) begin
                dmem_ack_i = 1'b1;
                dmem_rdata_i = 32'hCAFE_F00D;
                #1;
            end
            total++; if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL to_req[%0d]: got %b exp 1", i, dmem_req_o); end
            total++; if (stall_o !== (i < 4)) begin bad++; $display("FAIL to_stall[%0d]: got %b exp %b", i, stall_o, (i < 4)); end
        end
        @(negedge clk);
        dmem_ack_i = 1'b0;
        mem_valid_i = 1'b0;
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL to_req_drop: got %b exp 0", dmem_req_o); end
        if (ack_last) begin
            total++; if ({bus_err_o, wb_ctrl_o, data_o} !== {1'b0, 2'b11, 32'hCAFE_F00D}) begin bad++; $display("FAIL to_ack_last: got %b %b %h exp 0 11 cafef00d", bus_err_o, wb_ctrl_o, data_o); end
        end else begin
            total++; if ({bus_err_o, wb_ctrl_o} !== 3'b100) begin bad++; $display("FAIL to_buserr: got %b exp 100", {bus_err_o, wb_ctrl_o}); end
            @(negedge clk);
            total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL to_buserr_end: got %b exp 0", bus_err_o); end
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_op(1'b1, 5'b10010, 2'b11, 32'h0000_0300, 32'h0, 5'd6);
        @(negedge clk);
        total++; if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL rw_req_pre: got %b exp 1", dmem_req_o); end
        rst_i = 1'b1;
        #1;
        total++; if ({dmem_req_o, stall_o} !== 2'b00) begin bad++; $display("FAIL rw_async: got %b exp 00", {dmem_req_o, stall_o}); end
        @(negedge clk);
        mem_valid_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
        total++; if ({bus_err_o, misalign_o, wb_ctrl_o} !== 4'b0000) begin bad++; $display("FAIL rw_quiet: got %b exp 0000", {bus_err_o, misalign_o, wb_ctrl_o}); end
        drive_op(1'b1, 5'b00000, 2'b10, 32'h1234_5678, 32'h0, 5'd7);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL add_stall: got %b exp 0", stall_o); end
        @(negedge clk);
        mem_valid_i = 1'b0;
        total++; if ({wb_ctrl_o, wb_data_o, wb_Rd_o} !== {2'b10, 32'h1234_5678, 5'd7}) begin bad++; $display("FAIL add_wb: got %b %h %0d exp 10 12345678 7", wb_ctrl_o, wb_data_o, wb_Rd_o); end
        total++; if ({data_o, dmem_req_o} !== 33'h0) begin bad++; $display("FAIL add_data: got %h %b exp 0 0", data_o, dmem_req_o); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
